write_pixel: RTL and testbench

WS2812/NeoPixel single-pixel serializer. On a valid/busy handshake it accepts one 24-bit RGB colour and drives it onto a one-wire NeoPixel data line in GRB order, MSB first, using pulse-width bit encoding. It sits between the frame sequencer, which steps through the pixel colour table, and a PMOD output pin. The frame latch/reset gap (line held low ≥ 50 µs) is the sequencer's job and is not generated here.

---
 rtl/write_pixel_if.sv | 26 ++
 rtl/write_pixel.sv | 79 +++++++
 tb/tb_write_pixel.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/write_pixel_if.sv
// rtl/write_pixel_if.sv - pixel request handshake between frame sequencer and serializer
interface write_pixel_if;
  logic       valid;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       busy;

  // Sequencer side: offers a colour, watches busy to know it was taken
  modport master (
    output valid,
    output red,
    output green,
    output blue,
    input  busy
  );

  // Serializer side
  modport slave (
    input  valid,
    input  red,
    input  green,
    input  blue,
    output busy
  );
endinterface

// File: rtl/write_pixel.sv
// rtl/write_pixel.sv - WS2812 single-pixel GRB serializer with pulse-width bit encoding
module write_pixel #(
  parameter int T0H  = 5,
  parameter int T1H  = 10,
  parameter int TBIT = 15
) (
  input  logic         CLK,
  input  logic         RST_N,
  write_pixel_if.slave pix,
  output logic         dout
);

  localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [CW-1:0] TLAST_C = CW'(TBIT - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cyc_q,   cyc_d;
  logic [4:0]    bit_q,   bit_d;
  logic [23:0]   shift_q, shift_d;

  // Next-state: accept only from IDLE so a lingering valid cannot retrigger mid-pixel
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pix.valid) begin
          state_d = SEND;
          shift_d = {pix.green, pix.red, pix.blue};
          bit_d   = 5'd23;
          cyc_d   = '0;
        end
      end
      SEND: begin
        if (cyc_q == TLAST_C) begin
          cyc_d = '0;
          if (bit_q == 5'd0) begin
            state_d = IDLE;
          end else begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any partial pixel
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Outputs decode straight from registers so reset clears them without waiting for a clock
  always_comb begin
    pix.busy = (state_q == SEND);
    dout     = (state_q == SEND) && (cyc_q < (shift_q[23] ? T1H_C : T0H_C));
  end

endmodule

// File: tb/tb_write_pixel.sv
// tb/tb_write_pixel.sv - directed self-checking bench for write_pixel
module tb_write_pixel;

  logic CLK;
  logic RST_N;
  logic dout;
  int   n_cmp;
  int   n_bad;

  write_pixel_if pif ();

  write_pixel #(.T0H(5), .T1H(10), .TBIT(15)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .pix   (pif),
    .dout  (dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_colour(input logic [23:0] w);
    pif.green = w[23:16];
    pif.red   = w[15:8];
    pif.blue  = w[7:0];
  endtask

  // Call right after the negedge on which valid was raised for an IDLE block.
  // Checks every bit's 15-cycle dout pattern, busy throughout, then the low cycle E+361.
  task automatic check_pixel(input string tag, input logic [23:0] w,
                             input int drop_at, input int chg_at, input logic [23:0] chg_w);
    logic [14:0] pat;
    logic [14:0] expp;
    logic        busy_all;
    int          i;
    busy_all = 1'b1;
    i = 0;
    for (int k = 0; k < 24; k++) begin
      pat = '0;
      for (int c = 0; c < 15; c++) begin
        @(negedge CLK);
        pat[c]   = dout;
        busy_all = busy_all & pif.busy;
        if (i == drop_at) pif.valid = 1'b0;
        if (i == chg_at)  set_colour(chg_w);
        i++;
      end
      expp = w[23-k] ? 15'h03FF : 15'h001F;
      chk($sformatf("%s bit%0d pattern", tag, k), {17'd0, pat}, {17'd0, expp});
    end
    chk({tag, " busy 360"}, {31'd0, busy_all}, 32'd1);
    @(negedge CLK);
    chk({tag, " busy E+361"}, {31'd0, pif.busy}, 32'd0);
    chk({tag, " dout E+361"}, {31'd0, dout}, 32'd0);
  endtask

  task automatic idle_check(input string tag, input int n);
    logic any;
    any = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge CLK);
      any = any | pif.busy | dout;
    end
    chk({tag, " stays idle"}, {31'd0, any}, 32'd0);
  endtask

  logic [23:0] frame [10];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST_N = 1'b0;
    pif.valid = 1'b0;
    set_colour(24'h000000);
    frame[0] = 24'h123456; frame[1] = 24'hA5C30F; frame[2] = 24'h800001;
    frame[3] = 24'h00FF00; frame[4] = 24'hFFFFFE; frame[5] = 24'h5A5A5A;
    frame[6] = 24'h010080; frame[7] = 24'hC0FFEE; frame[8] = 24'h7E817E;
    frame[9] = 24'h000100;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset busy", {31'd0, pif.busy}, 32'd0);
    chk("reset dout", {31'd0, dout}, 32'd0);
    RST_N = 1'b1;
    idle_check("post reset", 5);

    // Single pixel: only red[5] (bit 10) is a '1'
    set_colour(24'h002000);
    pif.valid = 1'b1;
    check_pixel("red20", 24'h002000, 0, -1, 24'h0);

    // All ones
    @(negedge CLK);
    set_colour(24'hFFFFFF);
    pif.valid = 1'b1;
    check_pixel("ones", 24'hFFFFFF, 0, -1, 24'h0);

    // valid held 3 cycles after acceptance, colour scrambled during SEND
    @(negedge CLK);
    set_colour(24'h3C96E1);
    pif.valid = 1'b1;
    check_pixel("hold3", 24'h3C96E1, 3, 0, 24'hC3691E);
    idle_check("hold3", 40);

    // valid permanently high: back-to-back pixels, one low cycle between them
    @(negedge CLK);
    set_colour(24'h000001);
    pif.valid = 1'b1;
    check_pixel("cont1", 24'h000001, -1, -1, 24'h0);
    check_pixel("cont2", 24'h000001, -1, 50, 24'h000000);
    check_pixel("cont3", 24'h000000, 100, -1, 24'h0);
    idle_check("cont", 20);

    // Ten-pixel frame with sequencer handshake: raise valid, drop on busy
    for (int p = 0; p < 10; p++) begin
      @(negedge CLK);
      set_colour(frame[p]);
      pif.valid = 1'b1;
      check_pixel($sformatf("frame%0d", p), frame[p], 0, 5, ~frame[p]);
    end
    idle_check("frame end", 30);

    // Reset mid-pixel during bit 5
    @(negedge CLK);
    set_colour(24'hFFFFFF);
    pif.valid = 1'b1;
    for (int i = 0; i < 79; i++) begin
      @(negedge CLK);
      if (i == 0) pif.valid = 1'b0;
    end
    chk("bit5 dout before reset", {31'd0, dout}, 32'd1);
    chk("bit5 busy before reset", {31'd0, pif.busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mid reset dout", {31'd0, dout}, 32'd0);
    chk("mid reset busy", {31'd0, pif.busy}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    idle_check("after mid reset", 40);

    // Block still works after abandoned pixel
    @(negedge CLK);
    set_colour(24'h81007E);
    pif.valid = 1'b1;
    check_pixel("post reset pixel", 24'h81007E, 0, -1, 24'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
